// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Registered ripple-carry adder built from 1-bit full-adder cells.
//   The combinational core computes {c[WIDTH], s} = a + b + cin.
//   The result is captured in an output register on every rising clk edge.
//   With the default WIDTH=1 this is a clocked single-bit full adder.
//
// Parameters
//   WIDTH : operand width in bits (>= 1); a, b and sum share this width
//
// Ports
//   clk  : in  1      system clock, all state changes on the rising edge
//   rst  : in  1      synchronous, active-high reset (clears sum and cout)
//   cin  : in  1      carry into bit 0
//   a    : in  WIDTH  addend A, unsigned
//   b    : in  WIDTH  addend B, unsigned
//   sum  : out WIDTH  registered sum bits (modulo 2^WIDTH)
//   cout : out 1      registered carry out of the MSB
// -----------------------------------------------------------------------------
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Carry chain: c[0] is the external carry-in, c[WIDTH] is the carry-out.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_d;
    logic             cout_q;

    assign c[0] = cin;

    // Stage 0: combinational ripple-carry core, one full-adder cell per bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic p;  // propagate: carry passes through when exactly one operand bit is set

        assign p        = a[i] ^ b[i];
        assign s[i]     = p ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & p);
    end

    assign sum_d  = s;
    assign cout_d = c[WIDTH];

    // Stage 1: output register; reset takes priority over data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
//   Self-checking bench for full_adder. Three instances (WIDTH = 1, 4, 8)
//   share clk and rst. Expected results come from plain integer addition
//   a + b + cin, evaluated when the operands are applied and compared one
//   clock later.
// -----------------------------------------------------------------------------
module tb_full_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       a1 = '0, b1 = '0, cin1 = '0;
    logic       sum1;
    logic       cout1;

    logic [3:0] a4 = '0, b4 = '0;
    logic       cin4 = '0;
    logic [3:0] sum4;
    logic       cout4;

    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = '0;
    logic [7:0] sum8;
    logic       cout8;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_w1 (
        .clk (clk), .rst (rst), .cin (cin1), .a (a1), .b (b1),
        .sum (sum1), .cout (cout1)
    );

    full_adder #(.WIDTH(4)) u_w4 (
        .clk (clk), .rst (rst), .cin (cin4), .a (a4), .b (b4),
        .sum (sum4), .cout (cout4)
    );

    full_adder #(.WIDTH(8)) u_w8 (
        .clk (clk), .rst (rst), .cin (cin8), .a (a8), .b (b8),
        .sum (sum8), .cout (cout8)
    );

    // Reference: full-precision unsigned addition, result is {cout, sum}.
    function automatic logic [8:0] ref_add(input int unsigned a, input int unsigned b,
                                           input int unsigned cin, input int w);
        int unsigned r;
        r = (a + b + cin) % (32'd1 << (w + 1));
        return 9'(r);
    endfunction

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] obs1();
        return {7'd0, cout1, sum1};
    endfunction

    function automatic logic [8:0] obs4();
        return {4'd0, cout4, sum4};
    endfunction

    function automatic logic [8:0] obs8();
        return {cout8, sum8};
    endfunction

    initial begin
        logic [8:0] exp1, exp4, exp8;
        logic [2:0] vec;

        // Reset with all operands/carry high: outputs must clear anyway.
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        tick();
        check("reset_w1", obs1(), 9'h000);
        check("reset_w4", obs4(), 9'h000);
        check("reset_w8", obs8(), 9'h000);

        // First result after reset release: 1+1+1 = 3 -> sum=1, cout=1.
        rst = 1'b0;
        tick();
        check("first_after_reset_w1", obs1(), 9'h003);

        // Exhaustive WIDTH=1, one vector per edge.
        for (int i = 0; i < 8; i++) begin
            vec  = 3'(i);
            a1   = vec[2];
            b1   = vec[1];
            cin1 = vec[0];
            exp1 = ref_add(a1, b1, cin1, 1);
            tick();
            check($sformatf("exh_w1_abc=%b", vec), obs1(), exp1);
        end

        // Hold: outputs keep the last capture while inputs move between edges.
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
        exp1 = ref_add(1, 0, 0, 1);
        tick();
        check("hold_capture_w1", obs1(), exp1);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        #2;
        check("hold_between_edges_w1", obs1(), exp1);
        #1;
        check("hold_before_edge_w1", obs1(), exp1);
        tick();
        check("hold_next_edge_w1", obs1(), ref_add(1, 1, 1, 1));

        // WIDTH=4 wrap-around and a plain sum.
        a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1;
        tick();
        check("w4_F_0_1", obs4(), 9'h010);
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        tick();
        check("w4_F_F_1", obs4(), 9'h01F);
        a4 = 4'h5; b4 = 4'h3; cin4 = 1'b0;
        tick();
        check("w4_5_3_0", obs4(), 9'h008);

        // WIDTH=8 maximum result.
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        tick();
        check("w8_max", obs8(), 9'h1FF);

        // Mid-stream reset: back-to-back adds with a one-cycle rst pulse.
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1;
        tick();
        check("mid_before_w8", obs8(), ref_add(8'h12, 8'h34, 1, 8));
        a8 = 8'hA0; b8 = 8'h70; cin8 = 1'b0;
        rst = 1'b1;
        tick();
        check("mid_reset_w8", obs8(), 9'h000);
        check("mid_reset_w4", obs4(), 9'h000);
        rst = 1'b0;
        a8 = 8'hC3; b8 = 8'h5A; cin8 = 1'b1;
        tick();
        check("mid_after_w8", obs8(), ref_add(8'hC3, 8'h5A, 1, 8));

        // Random WIDTH=8 (and WIDTH=4 alongside), checked one cycle later.
        for (int n = 0; n < 1000; n++) begin
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            cin8 = 1'($urandom);
            a4   = 4'($urandom);
            b4   = 4'($urandom);
            cin4 = 1'($urandom);
            exp8 = ref_add(a8, b8, cin8, 8);
            exp4 = ref_add(a4, b4, cin4, 4);
            tick();
            check($sformatf("rand_w8_%0d", n), obs8(), exp8);
            check($sformatf("rand_w4_%0d", n), obs4(), exp4);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
